fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Decoupled instruction queue between instruction fetch and the decode stage's control unit.
- Absorbs fetch bursts and decode stalls, and carries {pc, inst, accessFault} per entry.
- Drops all in-flight entries on a pipeline redirect.
- Presents a canonical NOP (0x00000013) on the inst output whenever empty, so the combinational decoder never sees stale encodings.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, 32, width of pc and inst.
- NOP_INST, 32'h00000013, inst value driven while io_out_valid=0.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  fetch offers an entry.
- io_in_ready  out  1  buffer can accept an entry.
- io_in_bits_pc  in  XLEN  fetch PC.
- io_in_bits_inst  in  XLEN  fetched instruction word.
- io_in_bits_accessFault  in  1  fetch access fault on this entry.
- io_out_valid  out  1  head entry is valid.
- io_out_ready  in  1  decode consumes the head.
- io_out_bits_pc  out  XLEN  head PC.
- io_out_bits_inst  out  XLEN  head inst; NOP_INST when empty.
- io_out_bits_accessFault  out  1  head fault flag; 0 when empty.
- io_flush  in  1  redirect: discard all entries.
- io_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular array with rdPtr and wrPtr, each log2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - empty = (rdPtr == wrPtr).
  - full = index bits equal and MSBs differ.
  - io_count = wrPtr - rdPtr, modulo 2^(log2(DEPTH)+1).
- Reset (reset=0, asynchronous): rdPtr=0 and wrPtr=0. Resulting outputs: io_out_valid=0, io_in_ready=1, io_count=0, io_out_bits_inst=NOP_INST, io_out_bits_pc=0, io_out_bits_accessFault=0. Entry data is not reset.
- Enqueue fires when io_in_valid & io_in_ready & !io_flush. It writes the entry at wrPtr and increments wrPtr.
- Dequeue fires when io_out_valid & io_out_ready & !io_flush. It increments rdPtr.
- io_in_ready = !full, purely from state. There is no same-cycle pass-through of a dequeue slot into a full buffer.
- io_out_valid = !empty. Output bits come from the entry at rdPtr, so minimum latency is 1 cycle from enqueue to visibility.
- Empty output values: io_out_bits_inst=NOP_INST, io_out_bits_pc=0, io_out_bits_accessFault=0.
- Simultaneous enqueue and dequeue (neither full nor empty): both pointers advance and io_count is unchanged.
- Full with io_out_ready=1: dequeue proceeds. io_in_ready rises the following cycle.
- Pointer wrap: index bits wrap modulo DEPTH and the MSB toggles. No entry is lost across the wrap.
- Flush: io_flush=1 sets rdPtr <= wrPtr at the clock edge, emptying the buffer.
  - It overrides any same-cycle enqueue or dequeue; the incoming entry is dropped.
  - io_in_ready and io_out_valid still follow current state during the flush cycle.
  - Fetch ignores io_in_ready while flushing.
- Reset asserted mid-operation: pointers clear immediately (asynchronous). Outputs follow within the same cycle.
- Handshake rules:
  - An upstream offer, once made, is held until accepted or until a flush.
  - The buffer never drops an accepted entry except on flush or reset.

Decomposition:
- Shared package holds:
  - XLEN.
  - NOP_INST.
  - The fetch-packet type {pc, inst, accessFault}, reused by the fetch stage and the IF/ID interface.
- One natural sub-module, circular_queue: generic DEPTH x packet storage with pointers and full/empty logic.
- fetch_buffer wraps circular_queue and adds the flush override, NOP substitution and io_count.

Test Plan:
- Basic pass: after reset, enqueue pc=0x80000000, inst=0x00500093 with io_out_ready=1.
  - io_out_valid=1 the next cycle with those values.
  - The cycle after that, empty again: io_out_bits_inst=0x00000013.
- Fill to full: hold io_out_ready=0 and push 4 entries (pc 0x0, 0x4, 0x8, 0xC).
  - io_count=4 and io_in_ready=0.
  - A 5th offer (pc 0x10) is not accepted.
  - Releasing io_out_ready drains 0x0, 0x4, 0x8, 0xC, 0x10 in order.
- Simultaneous enqueue and dequeue at count=2 for 10 cycles with sequential PCs.
  - io_count stays 2.
  - Output PCs are strictly increasing by 4 across a pointer wrap.
- Flush with pending enqueue: count=3, io_flush=1 and io_in_valid=1 in the same cycle.
  - Next cycle io_count=0 and io_out_valid=0.
  - The flushed-cycle entry never appears at the output.
- Access fault propagation: enqueue an entry with accessFault=1 and inst=0xFFFFFFFF.
  - The output shows accessFault=1 with the same pc and inst.
  - The next entry shows accessFault=0.
- Async reset mid-stream: assert reset=0 between clock edges with count=3.
  - io_out_valid=0 and io_count=0 immediately, before the next edge.
  - After release, first enqueue appears 1 cycle later.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode path.
package fetch_buffer_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   // One fetched instruction as seen by the IF/ID boundary.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            access_fault;
   } fetch_packet_t;

endpackage

// File: rtl/circular_queue.sv
// Generic DEPTH-entry packet ring with wrap-bit pointers; clear snaps rd onto wr.
module circular_queue
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enq,
   input  fetch_packet_t            enq_data,
   input  logic                     deq,
   input  logic                     clear,
   output fetch_packet_t            head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   fetch_packet_t    mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointer state; clear wins over any same-cycle enq/deq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (clear) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Entry storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (enq && !clear) mem[wr_ptr[IDX_W-1:0]] <= enq_data;
   end

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                  (rd_ptr[IDX_W] != wr_ptr[IDX_W]);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue with redirect flush and NOP on empty.
module fetch_buffer
   import fetch_buffer_pkg::XLEN;
   import fetch_buffer_pkg::fetch_packet_t;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] NOP_INST = fetch_buffer_pkg::NOP_INST
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_in_valid,
   output logic                   io_in_ready,
   input  logic [XLEN-1:0]        io_in_bits_pc,
   input  logic [XLEN-1:0]        io_in_bits_inst,
   input  logic                   io_in_bits_accessFault,
   output logic                   io_out_valid,
   input  logic                   io_out_ready,
   output logic [XLEN-1:0]        io_out_bits_pc,
   output logic [XLEN-1:0]        io_out_bits_inst,
   output logic                   io_out_bits_accessFault,
   input  logic                   io_flush,
   output logic [$clog2(DEPTH):0] io_count
);

   fetch_packet_t in_pkt;
   fetch_packet_t head;
   logic          full;
   logic          empty;
   logic          enq;
   logic          deq;

   assign in_pkt = '{pc: io_in_bits_pc, inst: io_in_bits_inst,
                     access_fault: io_in_bits_accessFault};

   // Handshakes follow current state; a flush suppresses both transfers.
   assign io_in_ready  = !full;
   assign io_out_valid = !empty;
   assign enq = io_in_valid  && io_in_ready  && !io_flush;
   assign deq = io_out_valid && io_out_ready && !io_flush;

   circular_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clock),
      .rst_n    (reset),
      .enq      (enq),
      .enq_data (in_pkt),
      .deq      (deq),
      .clear    (io_flush),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (io_count)
   );

   // Decoder must never see a stale encoding while the queue is empty.
   always_comb begin
      io_out_bits_pc          = '0;
      io_out_bits_inst        = NOP_INST;
      io_out_bits_accessFault = 1'b0;
      if (!empty) begin
         io_out_bits_pc          = head.pc;
         io_out_bits_inst        = head.inst;
         io_out_bits_accessFault = head.access_fault;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized + directed bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            io_in_valid = 1'b0;
   logic            io_in_ready;
   logic [XLEN-1:0] io_in_bits_pc = '0;
   logic [XLEN-1:0] io_in_bits_inst = '0;
   logic            io_in_bits_accessFault = 1'b0;
   logic            io_out_valid;
   logic            io_out_ready = 1'b0;
   logic [XLEN-1:0] io_out_bits_pc;
   logic [XLEN-1:0] io_out_bits_inst;
   logic            io_out_bits_accessFault;
   logic            io_flush = 1'b0;
   logic [CW-1:0]   io_count;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .io_in_valid             (io_in_valid),
      .io_in_ready             (io_in_ready),
      .io_in_bits_pc           (io_in_bits_pc),
      .io_in_bits_inst         (io_in_bits_inst),
      .io_in_bits_accessFault  (io_in_bits_accessFault),
      .io_out_valid            (io_out_valid),
      .io_out_ready            (io_out_ready),
      .io_out_bits_pc          (io_out_bits_pc),
      .io_out_bits_inst        (io_out_bits_inst),
      .io_out_bits_accessFault (io_out_bits_accessFault),
      .io_flush                (io_flush),
      .io_count                (io_count)
   );

   always #5 clock = ~clock;

   int            n_checks = 0;
   int            n_pass   = 0;
   fetch_packet_t mdl[$];
   logic          accepted;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic check_outputs();
      check("count",     64'(io_count),     64'(mdl.size()));
      check("out_valid", 64'(io_out_valid), 64'(mdl.size() != 0));
      check("in_ready",  64'(io_in_ready),  64'(mdl.size() < DEPTH));
      if (mdl.size() != 0) begin
         check("out_pc",    64'(io_out_bits_pc),          64'(mdl[0].pc));
         check("out_inst",  64'(io_out_bits_inst),        64'(mdl[0].inst));
         check("out_fault", 64'(io_out_bits_accessFault), 64'(mdl[0].access_fault));
      end else begin
         check("empty_pc",    64'(io_out_bits_pc),          64'h0);
         check("empty_inst",  64'(io_out_bits_inst),        64'h13);
         check("empty_fault", 64'(io_out_bits_accessFault), 64'h0);
      end
   endtask

   // Check settled outputs, then advance one clock and update the model.
   task automatic step();
      int sz;
      fetch_packet_t pkt;
      #1 check_outputs();
      @(posedge clock);
      pkt = '{pc: io_in_bits_pc, inst: io_in_bits_inst, access_fault: io_in_bits_accessFault};
      sz = mdl.size();
      accepted = 1'b0;
      if (io_flush) mdl.delete();
      else begin
         if (io_out_ready && sz > 0) void'(mdl.pop_front());
         if (io_in_valid && sz < DEPTH) begin
            mdl.push_back(pkt);
            accepted = 1'b1;
         end
      end
      @(negedge clock);
   endtask

   task automatic offer(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst, input logic af);
      io_in_valid = 1'b1;
      io_in_bits_pc = pc;
      io_in_bits_inst = inst;
      io_in_bits_accessFault = af;
   endtask

   initial begin
      // Reset state
      #1 check_outputs();
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Basic pass
      io_out_ready = 1'b1;
      offer(32'h8000_0000, 32'h0050_0093, 1'b0);
      step();
      io_in_valid = 1'b0;
      step();
      step();

      // Fill to full, fifth offer held, then drain
      io_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         offer(32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0);
         step();
      end
      check("full_count", 64'(io_count), 64'd4);
      check("full_ready", 64'(io_in_ready), 64'd0);
      io_out_ready = 1'b1;
      while (!accepted && n_checks < 10000) step();
      io_in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Streaming at count=2 across pointer wrap
      io_out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(32'h100 + 32'(i * 4), 32'h2000_0000, 1'b0);
         step();
      end
      io_out_ready = 1'b1;
      for (int i = 2; i < 12; i++) begin
         offer(32'h100 + 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0);
         step();
         check("stream_count", 64'(io_count), 64'd2);
      end

      // Flush with pending enqueue at count=3
      io_out_ready = 1'b0;
      offer(32'h200, 32'h3000_0000, 1'b0);
      step();
      check("pre_flush_count", 64'(io_count), 64'd3);
      io_flush = 1'b1;
      offer(32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0);
      step();
      io_flush = 1'b0;
      io_in_valid = 1'b0;
      check("flush_count", 64'(io_count), 64'd0);
      check("flush_valid", 64'(io_out_valid), 64'd0);
      step();

      // Access fault propagation
      offer(32'h300, 32'hFFFF_FFFF, 1'b1);
      step();
      offer(32'h304, 32'h0000_0093, 1'b0);
      step();
      io_in_valid = 1'b0;
      io_out_ready = 1'b1;
      repeat (3) step();

      // Async reset mid-stream with count=3
      io_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(32'h400 + 32'(i * 4), 32'h4000_0000, 1'b0);
         step();
      end
      io_in_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check("arst_valid", 64'(io_out_valid), 64'd0);
      check("arst_count", 64'(io_count), 64'd0);
      check("arst_inst", 64'(io_out_bits_inst), 64'h13);
      mdl.delete();
      @(negedge clock);
      reset = 1'b1;
      offer(32'h500, 32'h0050_0093, 1'b0);
      step();
      io_in_valid = 1'b0;
      check("post_rst_valid", 64'(io_out_valid), 64'd1);
      step();

      // Randomized traffic; offers held until accepted or flushed
      io_in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!io_in_valid && ($urandom_range(0, 3) != 0))
            offer($urandom, $urandom, 1'($urandom_range(0, 7) == 0));
         io_out_ready = 1'($urandom_range(0, 2) != 0);
         io_flush     = ($urandom_range(0, 19) == 0);
         step();
         if (accepted || io_flush) io_in_valid = 1'b0;
         io_flush = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
